// File: rtl/sort_stream_n.sv
// Streaming odd-even transposition sorter: AXI-Lite control, AXI-Stream in/out.
// Define SORT_STREAM_SIGNED_EN to make mode bit1 select two's-complement compare.
module sort_stream_n #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int pDEPTH      = 16
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst,
    input  logic                   awvalid,
    output logic                   awready,
    input  logic [pADDR_WIDTH-1:0] awaddr,
    input  logic                   wvalid,
    output logic                   wready,
    input  logic [pDATA_WIDTH-1:0] wdata,
    input  logic                   arvalid,
    output logic                   arready,
    input  logic [pADDR_WIDTH-1:0] araddr,
    output logic                   rvalid,
    input  logic                   rready,
    output logic [pDATA_WIDTH-1:0] rdata,
    input  logic                   ss_tvalid,
    output logic                   ss_tready,
    input  logic [pDATA_WIDTH-1:0] ss_tdata,
    input  logic                   ss_tlast,
    output logic                   sm_tvalid,
    input  logic                   sm_tready,
    output logic [pDATA_WIDTH-1:0] sm_tdata,
    output logic                   sm_tlast
);

    localparam int CW = $clog2(pDEPTH + 1);
    localparam int AW = $clog2(pDEPTH);
    localparam logic [CW-1:0]          DEPTH_N   = CW'(pDEPTH);
    localparam logic [pDATA_WIDTH-1:0] DEPTH_W   = pDATA_WIDTH'(pDEPTH);
    localparam logic [pADDR_WIDTH-1:0] ADDR_CTRL = pADDR_WIDTH'('h00);
    localparam logic [pADDR_WIDTH-1:0] ADDR_LEN  = pADDR_WIDTH'('h10);
    localparam logic [pADDR_WIDTH-1:0] ADDR_MODE = pADDR_WIDTH'('h14);

    typedef enum logic [1:0] {IDLE, LOAD, SORT, OUT} state_t;

    state_t                 state_q;
    logic [pDATA_WIDTH-1:0] buf_q [pDEPTH];
    logic [pDATA_WIDTH-1:0] buf_d [pDEPTH];
    logic [CW-1:0]          idx_q, n_q, pass_q, len_q;
    logic                   desc_q, done_q, short_q;
`ifdef SORT_STREAM_SIGNED_EN
    logic                   sgn_q;
`endif
    logic                   wr_ack_q, arready_q, rvalid_q, rd_ctrl_q;
    logic [pDATA_WIDTH-1:0] rdata_q, rd_val;
    logic [CW-1:0]          last_idx;
    logic                   wr_fire, rd_fire, r_fire;

    assign last_idx = n_q - CW'(1);
    assign wr_fire  = wr_ack_q & awvalid & wvalid;
    assign rd_fire  = arready_q & arvalid;
    assign r_fire   = rvalid_q & rready;

    function automatic logic outOfOrder(input logic [pDATA_WIDTH-1:0] a,
                                        input logic [pDATA_WIDTH-1:0] b);
        logic gt, lt;
        gt = (a > b);
        lt = (a < b);
`ifdef SORT_STREAM_SIGNED_EN
        if (sgn_q) begin
            gt = ($signed(a) > $signed(b));
            lt = ($signed(a) < $signed(b));
        end
`endif
        return desc_q ? lt : gt;
    endfunction

    // One compare-exchange stage; pass parity picks even or odd pairs, pairs beyond n stay put.
    always_comb begin
        buf_d = buf_q;
        for (int i = 0; i + 1 < pDEPTH; i++) begin
            if (((i % 2) == int'(pass_q[0])) && ((i + 1) < int'(n_q))) begin
                if (outOfOrder(buf_q[i], buf_q[i+1])) begin
                    buf_d[i]   = buf_q[i+1];
                    buf_d[i+1] = buf_q[i];
                end
            end
        end
    end

    always_comb begin
        rd_val = '0;
        if (araddr == ADDR_CTRL) begin
            rd_val[3:0] = {short_q, (state_q == IDLE), done_q, 1'b0};
        end else if (araddr == ADDR_LEN) begin
            rd_val[CW-1:0] = len_q;
        end else if (araddr == ADDR_MODE) begin
            rd_val[0] = desc_q;
`ifdef SORT_STREAM_SIGNED_EN
            rd_val[1] = sgn_q;
`endif
        end
    end

    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            state_q   <= IDLE;
            for (int i = 0; i < pDEPTH; i++) buf_q[i] <= '0;
            idx_q     <= '0;
            n_q       <= DEPTH_N;
            pass_q    <= '0;
            len_q     <= DEPTH_N;
            desc_q    <= 1'b0;
`ifdef SORT_STREAM_SIGNED_EN
            sgn_q     <= 1'b0;
`endif
            done_q    <= 1'b0;
            short_q   <= 1'b0;
            wr_ack_q  <= 1'b0;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rd_ctrl_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            wr_ack_q <= awvalid && wvalid && !wr_ack_q;
            if (rd_fire) begin
                arready_q <= 1'b0;
                rvalid_q  <= 1'b1;
                rdata_q   <= rd_val;
                rd_ctrl_q <= (araddr == ADDR_CTRL);
            end
            if (r_fire) begin
                rvalid_q  <= 1'b0;
                arready_q <= 1'b1;
                if (rd_ctrl_q) done_q <= 1'b0;
            end
            if (wr_fire && state_q == IDLE) begin
                if (awaddr == ADDR_LEN) begin
                    len_q <= (wdata == '0) ? CW'(1) :
                             (wdata > DEPTH_W) ? DEPTH_N : wdata[CW-1:0];
                end
                if (awaddr == ADDR_MODE) begin
                    desc_q <= wdata[0];
`ifdef SORT_STREAM_SIGNED_EN
                    sgn_q  <= wdata[1];
`endif
                end
            end
            // A done set by the final output beat overrides a same-cycle clear-on-read.
            case (state_q)
                IDLE: if (wr_fire && awaddr == ADDR_CTRL && wdata[0]) begin
                    state_q <= LOAD;
                    done_q  <= 1'b0;
                    short_q <= 1'b0;
                    idx_q   <= '0;
                    n_q     <= len_q;
                end
                LOAD: if (ss_tvalid) begin
                    buf_q[idx_q[AW-1:0]] <= ss_tdata;
                    if (idx_q == last_idx) begin
                        state_q <= SORT;
                        pass_q  <= '0;
                    end else if (ss_tlast) begin
                        n_q     <= idx_q + CW'(1);
                        short_q <= 1'b1;
                        state_q <= SORT;
                        pass_q  <= '0;
                    end else begin
                        idx_q <= idx_q + CW'(1);
                    end
                end
                SORT: begin
                    buf_q <= buf_d;
                    if (pass_q == last_idx) begin
                        state_q <= OUT;
                        idx_q   <= '0;
                    end else begin
                        pass_q <= pass_q + CW'(1);
                    end
                end
                OUT: if (sm_tready) begin
                    if (idx_q == last_idx) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end else begin
                        idx_q <= idx_q + CW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign awready   = wr_ack_q;
    assign wready    = wr_ack_q;
    assign arready   = arready_q;
    assign rvalid    = rvalid_q;
    assign rdata     = rdata_q;
    assign ss_tready = (state_q == LOAD);
    assign sm_tvalid = (state_q == OUT);
    assign sm_tdata  = sm_tvalid ? buf_q[idx_q[AW-1:0]] : '0;
    assign sm_tlast  = sm_tvalid && (idx_q == last_idx);

endmodule
